// File: rtl/io_txframe_if.sv
// io_txframe_if: packet-word read port and byte-stream link port of the IO transmit framer.
interface io_txframe_if;
    logic        rd_req;
    logic        rd_dval;
    logic [17:0] rd_data;
    logic [7:0]  tx_byte;
    logic        tx_bval;
    logic        tx_brdy;
    modport master (output rd_req, tx_byte, tx_bval, input rd_dval, rd_data, tx_brdy);
    modport slave  (input rd_req, tx_byte, tx_bval, output rd_dval, rd_data, tx_brdy);
endinterface

// File: rtl/io_txframe.sv
// io_txframe: frames upstream packet words into an SOF/payload/CRC-16/EOF byte stream for the IO link.
module io_txframe #(
    parameter int MAX_WORDS = 512,
    parameter int RD_TMO    = 8,
    parameter int IFG       = 4
) (
    input  logic         clk_12_5m,
    input  logic         rst_12_5m,
    input  logic         tx_en,
    io_txframe_if.master io,
    output logic         tx_busy,
    output logic [15:0]  frm_cnt,
    output logic [7:0]   err_cnt
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int TW = $clog2(RD_TMO + 1);
    localparam int GW = $clog2(IFG + 1);
    typedef enum logic [3:0] {IDLE, REQ, WAIT, SOF, HI, LO, CRCH, CRCL, EOF, GAP} state_t;
    state_t state, state_n;
    logic frame, frame_n, bad, bad_n, held, held_n, drain, drain_n, acc, err_inc;
    logic [16:0] word, word_n;
    logic [CW-1:0] wcnt, wcnt_n;
    logic [15:0] crc, crc_n, frm_n, crc_o;
    logic [TW-1:0] tmo, tmo_n;
    logic [GW-1:0] gap, gap_n;
    logic [7:0] err_n, byte_n;
    logic rd_req_n, bval_n, busy_n;

    function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
        return r;
    endfunction

    assign acc = io.tx_bval & io.tx_brdy;

    always_comb begin
        state_n = state;
        frame_n = frame;
        bad_n   = bad;
        held_n  = held;
        drain_n = drain;
        word_n  = word;
        wcnt_n  = wcnt;
        crc_n   = crc;
        tmo_n   = tmo;
        gap_n   = gap;
        frm_n   = frm_cnt;
        err_inc = 1'b0;
        unique case (state)
            IDLE: if (tx_en) begin
                state_n = REQ;
                frame_n = 1'b0;
            end
            REQ: begin
                tmo_n   = '0;
                state_n = WAIT;
            end
            WAIT: if (io.rd_dval) begin
                word_n = io.rd_data[16:0];
                if (drain) begin
                    drain_n = ~io.rd_data[16];
                    state_n = io.rd_data[16] ? IDLE : REQ;
                end else if (!frame) begin
                    if (io.rd_data[17]) begin
                        wcnt_n  = '0;
                        crc_n   = 16'hFFFF;
                        state_n = SOF;
                    end else begin
                        err_inc = 1'b1;
                        state_n = IDLE;
                    end
                end else if (io.rd_data[17]) begin
                    // the new sop word stays in the word register to open the next frame
                    err_inc = 1'b1;
                    bad_n   = 1'b1;
                    held_n  = 1'b1;
                    state_n = CRCH;
                end else if (wcnt == CW'(MAX_WORDS)) begin
                    err_inc = 1'b1;
                    bad_n   = 1'b1;
                    drain_n = ~io.rd_data[16];
                    state_n = CRCH;
                end else begin
                    wcnt_n  = wcnt + 1'b1;
                    state_n = HI;
                end
            end else if (tmo == TW'(RD_TMO - 1)) begin
                drain_n = 1'b0;
                err_inc = frame;
                bad_n   = frame;
                state_n = frame ? CRCH : IDLE;
            end else tmo_n = tmo + 1'b1;
            SOF: if (acc) begin
                frame_n = 1'b1;
                wcnt_n  = CW'(1);
                state_n = HI;
            end
            HI: if (acc) begin
                crc_n   = crc8(crc, word[15:8]);
                state_n = LO;
            end
            LO: if (acc) begin
                crc_n   = crc8(crc, word[7:0]);
                state_n = word[16] ? CRCH : REQ;
            end
            CRCH: if (acc) state_n = CRCL;
            CRCL: if (acc) state_n = EOF;
            EOF: if (acc) begin
                frame_n = 1'b0;
                gap_n   = '0;
                frm_n   = bad ? frm_cnt : frm_cnt + 16'd1;
                state_n = GAP;
            end
            GAP: if (gap == GW'(IFG - 1)) begin
                bad_n   = 1'b0;
                held_n  = 1'b0;
                crc_n   = held ? 16'hFFFF : crc;
                wcnt_n  = held ? '0 : wcnt;
                state_n = held ? SOF : drain ? REQ : IDLE;
            end else gap_n = gap + 1'b1;
            default: state_n = IDLE;
        endcase
        err_n = (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

    // outputs are registered from next-state values so bytes appear the cycle after acceptance
    assign crc_o    = crc_n ^ {16{bad_n}};
    assign rd_req_n = state_n == REQ;
    assign bval_n   = state_n inside {SOF, HI, LO, CRCH, CRCL, EOF};
    assign busy_n   = state_n != IDLE;
    assign byte_n   = state_n == SOF  ? 8'hA5 :
                      state_n == HI   ? word_n[15:8] :
                      state_n == LO   ? word_n[7:0] :
                      state_n == CRCH ? crc_o[15:8] :
                      state_n == CRCL ? crc_o[7:0] :
                      state_n == EOF  ? 8'h5A : 8'h00;

    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            state      <= IDLE;
            frame      <= 1'b0;
            bad        <= 1'b0;
            held       <= 1'b0;
            drain      <= 1'b0;
            word       <= '0;
            wcnt       <= '0;
            crc        <= 16'hFFFF;
            tmo        <= '0;
            gap        <= '0;
            frm_cnt    <= '0;
            err_cnt    <= '0;
            io.rd_req  <= 1'b0;
            io.tx_bval <= 1'b0;
            io.tx_byte <= 8'h00;
            tx_busy    <= 1'b0;
        end else begin
            state      <= state_n;
            frame      <= frame_n;
            bad        <= bad_n;
            held       <= held_n;
            drain      <= drain_n;
            word       <= word_n;
            wcnt       <= wcnt_n;
            crc        <= crc_n;
            tmo        <= tmo_n;
            gap        <= gap_n;
            frm_cnt    <= frm_n;
            err_cnt    <= err_n;
            io.rd_req  <= rd_req_n;
            io.tx_bval <= bval_n;
            io.tx_byte <= byte_n;
            tx_busy    <= busy_n;
        end
    end
endmodule

// File: tb/tb_io_txframe.sv
// tb_io_txframe: randomized scoreboard bench for io_txframe against a packet-level framing model.
module tb_io_txframe;
    localparam int MAXW = 4, TMO = 8, GAPC = 4;
    logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0;
    logic tx_busy;
    logic [15:0] frm_cnt;
    logic [7:0] err_cnt;
    io_txframe_if io();
    io_txframe #(.MAX_WORDS(MAXW), .RD_TMO(TMO), .IFG(GAPC)) dut (
        .clk_12_5m(clk), .rst_12_5m(rst_n), .tx_en(tx_en), .io(io),
        .tx_busy(tx_busy), .frm_cnt(frm_cnt), .err_cnt(err_cnt));

    always #40 clk = ~clk;

    typedef struct {bit tmo; logic [17:0] w; int dly;} item_t;
    item_t up_q[$];
    logic [8:0] exp_q[$];
    int n_chk = 0, n_pass = 0, brdy_mode = 0;
    bit mon_en = 1'b0;
    int m_mode = 0, m_cnt = 0, m_err = 0, m_frm = 0;
    logic [15:0] m_crc = 16'hFFFF;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] crc_upd(logic [15:0] c, logic [7:0] b);
        for (int i = 7; i >= 0; i--) c = (c[15] ^ b[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    task automatic m_bytes(logic [15:0] w);
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b0, w[7:0]});
        m_crc = crc_upd(crc_upd(m_crc, w[15:8]), w[7:0]);
    endtask

    task automatic m_close(bit bad);
        logic [15:0] c;
        c = bad ? ~m_crc : m_crc;
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b0, c[7:0]});
        exp_q.push_back(9'h15A);
        if (bad) m_err++; else m_frm++;
        m_mode = 0;
    endtask

    task automatic m_start(logic [17:0] w);
        exp_q.push_back(9'h0A5);
        m_crc = 16'hFFFF;
        m_cnt = 1;
        m_mode = 1;
        m_bytes(w[15:0]);
        if (w[16]) m_close(0);
    endtask

    // queue one upstream response and advance the packet-level model: 0 idle, 1 in frame, 2 draining
    task automatic issue(bit tmo, logic [17:0] w, int dly);
        item_t it;
        it.tmo = tmo; it.w = w; it.dly = dly;
        up_q.push_back(it);
        if (m_mode == 0) begin
            if (!tmo) begin
                if (w[17]) m_start(w); else m_err++;
            end
        end else if (m_mode == 2) begin
            if (tmo || w[16]) m_mode = 0;
        end else if (tmo) m_close(1);
        else if (w[17]) begin
            m_close(1);
            m_start(w);
        end else if (m_cnt == MAXW) begin
            m_close(1);
            m_mode = w[16] ? 0 : 2;
        end else begin
            m_cnt++;
            m_bytes(w[15:0]);
            if (w[16]) m_close(0);
        end
    endtask

    task automatic settle(string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || up_q.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drained"}, exp_q.size() + up_q.size(), 0);
        repeat (40) @(negedge clk);
        tx_en = 1'b0;
        repeat (20) @(negedge clk);
        chk({nm, "_frm"}, frm_cnt, m_frm);
        chk({nm, "_err"}, err_cnt, m_err);
        chk({nm, "_busy"}, tx_busy, 0);
    endtask

    initial begin
        item_t it;
        io.rd_dval = 1'b0;
        io.rd_data = '0;
        forever begin
            @(negedge clk);
            if (io.rd_req && up_q.size() > 0) begin
                it = up_q.pop_front();
                if (!it.tmo) begin
                    @(posedge clk);
                    repeat (it.dly - 1) @(posedge clk);
                    #1 io.rd_dval = 1'b1;
                    io.rd_data = it.w;
                    @(posedge clk);
                    #1 io.rd_dval = 1'b0;
                end
            end
        end
    end

    initial begin
        io.tx_brdy = 1'b0;
        forever begin
            @(negedge clk);
            io.tx_brdy = brdy_mode == 0 ? 1'b1 : brdy_mode == 1 ? ~io.tx_brdy : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        bit pend, armed;
        int gap;
        logic [7:0] last;
        logic [8:0] e;
        pend = 0; armed = 0; gap = 0; last = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                pend = 0;
                armed = 0;
            end else begin
                if (pend) begin
                    chk("bval_held", io.tx_bval, 1);
                    if (io.tx_bval) chk("byte_stable", io.tx_byte, last);
                end
                if (armed && io.tx_bval) begin
                    chk("ifg_gap", gap >= GAPC ? GAPC : gap, GAPC);
                    armed = 0;
                end else if (armed) gap++;
                pend = io.tx_bval && !io.tx_brdy;
                last = io.tx_byte;
                if (io.tx_bval && io.tx_brdy) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_byte: got %02h with nothing expected", io.tx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", io.tx_byte, e[7:0]);
                        if (e[8]) begin
                            armed = 1;
                            gap = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #(80 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        item_t it;
        logic [8:0] p1 [6];
        int len, n;
        logic [17:0] w;
        p1 = '{9'h0A5, 9'h000, 9'h000, 9'h01D, 9'h00F, 9'h15A};
        repeat (3) @(negedge clk);
        chk("rst_rd_req", io.rd_req, 0);
        chk("rst_bval", io.tx_bval, 0);
        chk("rst_byte", io.tx_byte, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_frm", frm_cnt, 0);
        chk("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        brdy_mode = 0;
        it.tmo = 0; it.w = 18'h30000; it.dly = 1;
        up_q.push_back(it);
        foreach (p1[i]) exp_q.push_back(p1[i]);
        m_frm = 1;
        tx_en = 1'b1;
        settle("single_word");
        brdy_mode = 1;
        issue(0, 18'h21234, 1);
        issue(0, 18'h15678, 2);
        tx_en = 1'b1;
        settle("two_words_stall");
        brdy_mode = 2;
        issue(0, 18'h0BEEF, 1);
        issue(0, 18'h3CAFE, 2);
        tx_en = 1'b1;
        settle("no_sop");
        issue(0, 18'h21111, 1);
        issue(1, 18'h0, 1);
        tx_en = 1'b1;
        settle("truncate");
        issue(0, 18'h2AAAA, 1);
        issue(0, 18'h2BBBB, 1);
        issue(0, 18'h1CCCC, 3);
        tx_en = 1'b1;
        settle("mid_sop");
        brdy_mode = 0;
        issue(0, 18'h20001, 1);
        for (int i = 2; i <= 5; i++) issue(0, {2'b00, 16'(i)}, 1);
        issue(0, 18'h10006, 1);
        tx_en = 1'b1;
        settle("overrun");
        brdy_mode = 2;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                w = {k == 0, k == len - 1, 16'($urandom)};
                n = $urandom_range(0, 15);
                if (n == 0) issue(1, w, 1);
                else issue(0, n == 1 ? {~w[17], w[16:0]} : w, $urandom_range(1, 4));
            end
        end
        if (m_mode != 0) issue(1, 18'h0, 1);
        tx_en = 1'b1;
        settle("random");
        brdy_mode = 0;
        issue(0, 18'h21357, 1);
        issue(0, 18'h02468, 1);
        issue(0, 18'h1ABCD, 1);
        tx_en = 1'b1;
        n = 0;
        while (!io.tx_bval && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_started", io.tx_bval, 1);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_bval", io.tx_bval, 0);
        chk("abort_busy", tx_busy, 0);
        chk("abort_frm", frm_cnt, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_rd_req", io.rd_req, 0);
        exp_q.delete();
        up_q.delete();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
